// File: rtl/ofm_out_fsm.sv
// rtl/ofm_out_fsm.sv - TX-domain reader of the offload ctrl/data FIFOs feeding the 10G MAC stream
// Optional feature macro: OFM_UDP_ZERO_FIX_EN (a zero checksum is written as 16'hFFFF)
module ofm_out_fsm #(
  parameter int C_BEAT_CNT_W = 13,
  parameter int C_IFG_CYCLES = 0
) (
  input  logic        tx_clk,
  input  logic        tx_reset,
  input  logic [33:0] ctrl_fifo_rdata,
  input  logic        ctrl_fifo_empty,
  output logic        ctrl_fifo_rden,
  input  logic [72:0] data_fifo_rdata,
  input  logic        data_fifo_empty,
  output logic        data_fifo_rden,
  output logic [63:0] tx_axis_tdata,
  output logic [7:0]  tx_axis_tkeep,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready,
  output logic        cs_unsupported,
  output logic [3:0]  ofm_out_fsm_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_IFG  = 2'd2
  } state_t;

  localparam logic [15:0] IFG_LOAD = 16'(C_IFG_CYCLES);
  localparam logic [C_BEAT_CNT_W-1:0] BEAT_MAX = '1;

  state_t                  state;
  state_t                  state_nxt;
  logic [15:0]             sum_q;
  logic [15:0]             ins_q;
  logic [1:0]              cntrl_q;
  logic [C_BEAT_CNT_W-1:0] beat_cnt;
  logic [15:0]             ifg_cnt;
  logic                    out_free;
  logic                    ctrl_pop;
  logic                    data_pop;
  logic                    beat_last;
  logic                    ins_hit;
  logic [15:0]             ins_sum;
  logic [63:0]             beat_data;

  // The output register can take a new beat when empty or being handed off this cycle.
  assign out_free  = !tx_axis_tvalid || tx_axis_tready;
  assign beat_last = data_fifo_rdata[72];

  assign ctrl_fifo_rden  = ctrl_pop;
  assign data_fifo_rden  = data_pop;
  assign cs_unsupported  = ctrl_pop && ctrl_fifo_rdata[33];
  assign ofm_out_fsm_dbg = {2'b00, state};

  // State register.
  always_ff @(posedge tx_clk or posedge tx_reset) begin
    if (tx_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and FIFO pop decisions; a ctrl word only exists once its frame is fully buffered.
  always_comb begin
    state_nxt = state;
    ctrl_pop  = 1'b0;
    data_pop  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!ctrl_fifo_empty && out_free) begin
          ctrl_pop  = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (!data_fifo_empty && out_free) begin
          data_pop = 1'b1;
          if (beat_last) state_nxt = (C_IFG_CYCLES > 0) ? S_IFG : S_IDLE;
        end
      end
      S_IFG: begin
        if (ifg_cnt <= 16'd1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Checksum overwrite of the popped beat: two bytes at the even lane, high byte first on the wire.
  always_comb begin
    ins_sum = sum_q;
`ifdef OFM_UDP_ZERO_FIX_EN
    if (sum_q == 16'h0000) ins_sum = 16'hFFFF;
`endif
    ins_hit   = (cntrl_q == 2'b01) && (beat_cnt == C_BEAT_CNT_W'(ins_q[15:3]));
    beat_data = data_fifo_rdata[63:0];
    for (int i = 0; i < 8; i++) begin
      if (ins_hit && (4'(i) == {1'b0, ins_q[2:0]}))
        beat_data[8*i +: 8] = ins_sum[15:8];
      if (ins_hit && (4'(i) == ({1'b0, ins_q[2:0]} + 4'd1)))
        beat_data[8*i +: 8] = ins_sum[7:0];
    end
  end

  // Latch the per-frame offload control when the ctrl word is popped.
  always_ff @(posedge tx_clk or posedge tx_reset) begin
    if (tx_reset) begin
      sum_q   <= '0;
      ins_q   <= '0;
      cntrl_q <= '0;
    end else if (ctrl_pop) begin
      sum_q   <= ctrl_fifo_rdata[15:0];
      ins_q   <= ctrl_fifo_rdata[31:16];
      cntrl_q <= ctrl_fifo_rdata[33:32];
    end
  end

  // In-frame beat index; saturates so oversize frames never alias back onto the insert beat.
  always_ff @(posedge tx_clk or posedge tx_reset) begin
    if (tx_reset)                             beat_cnt <= '0;
    else if (ctrl_pop)                        beat_cnt <= '0;
    else if (data_pop && beat_cnt != BEAT_MAX) beat_cnt <= beat_cnt + 1'b1;
  end

  // Inter-frame gap countdown.
  always_ff @(posedge tx_clk or posedge tx_reset) begin
    if (tx_reset)                              ifg_cnt <= '0;
    else if (data_pop && beat_last)            ifg_cnt <= IFG_LOAD;
    else if (state == S_IFG && ifg_cnt != '0)  ifg_cnt <= ifg_cnt - 16'd1;
  end

  // Output register: load on pop, drop valid after a handshake with nothing new, hold under backpressure.
  always_ff @(posedge tx_clk or posedge tx_reset) begin
    if (tx_reset) begin
      tx_axis_tvalid <= 1'b0;
      tx_axis_tdata  <= '0;
      tx_axis_tkeep  <= '0;
      tx_axis_tlast  <= 1'b0;
    end else if (data_pop) begin
      tx_axis_tvalid <= 1'b1;
      tx_axis_tdata  <= beat_data;
      tx_axis_tkeep  <= data_fifo_rdata[71:64];
      tx_axis_tlast  <= beat_last;
    end else if (tx_axis_tready) begin
      tx_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofm_out_fsm.sv
// tb/tb_ofm_out_fsm.sv - directed bench for ofm_out_fsm
module tb_ofm_out_fsm;

  logic        tx_clk = 1'b0;
  logic        tx_reset;
  logic [33:0] ctrl_fifo_rdata;
  logic        ctrl_fifo_empty;
  logic        ctrl_fifo_rden;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_empty;
  logic        data_fifo_rden;
  logic [63:0] tx_axis_tdata;
  logic [7:0]  tx_axis_tkeep;
  logic        tx_axis_tvalid;
  logic        tx_axis_tlast;
  logic        tx_axis_tready;
  logic        cs_unsupported;
  logic [3:0]  ofm_out_fsm_dbg;

  ofm_out_fsm dut (
    .tx_clk          (tx_clk),
    .tx_reset        (tx_reset),
    .ctrl_fifo_rdata (ctrl_fifo_rdata),
    .ctrl_fifo_empty (ctrl_fifo_empty),
    .ctrl_fifo_rden  (ctrl_fifo_rden),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rden  (data_fifo_rden),
    .tx_axis_tdata   (tx_axis_tdata),
    .tx_axis_tkeep   (tx_axis_tkeep),
    .tx_axis_tvalid  (tx_axis_tvalid),
    .tx_axis_tlast   (tx_axis_tlast),
    .tx_axis_tready  (tx_axis_tready),
    .cs_unsupported  (cs_unsupported),
    .ofm_out_fsm_dbg (ofm_out_fsm_dbg)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct packed {
    logic        rdy;
    logic        crd;
    logic        drd;
    logic        tv;
    logic        tl;
    logic [7:0]  tk;
    logic [63:0] td;
  } vec_t;

  typedef struct packed {
    logic [1:0]  cntrl;
    logic [15:0] ins;
    logic [15:0] sum;
    int          nb;
    int          hit_beat;
    int          lane;
    logic [15:0] word;
  } ins_t;

  vec_t        vt[16];
  ins_t        it[6];
  logic [33:0] cq[$];
  logic [72:0] dq[$];
  logic [72:0] cap[$];
  int          cap_cyc[$];
  logic        rdy = 1'b1;
  logic        dstall = 1'b0;
  logic        both_seen = 1'b0;
  logic        s_crd, s_drd, s_tv, s_tl;
  logic [7:0]  s_tk;
  logic [63:0] s_td;
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          unsup_cnt = 0;

  function automatic logic [63:0] pat(input int base, input int i);
    return {8'(base), 8'(i), 8'h5A, 8'hC3, 8'(base + i), 8'h11, 8'h22, 8'h33};
  endfunction

  function automatic vec_t mkv(input logic r, input logic c, input logic d, input logic v,
                               input logic l, input logic [7:0] k, input logic [63:0] t);
    vec_t x;
    x.rdy = r; x.crd = c; x.drd = d; x.tv = v; x.tl = l; x.tk = k; x.td = t;
    return x;
  endfunction

  function automatic ins_t mki(input logic [1:0] c, input logic [15:0] ins, input logic [15:0] sum,
                               input int nb, input int hb, input int lane, input logic [15:0] w);
    ins_t x;
    x.cntrl = c; x.ins = ins; x.sum = sum; x.nb = nb; x.hit_beat = hb; x.lane = lane; x.word = w;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_frame(input logic [1:0] cntrl, input logic [15:0] ins, input logic [15:0] sum,
                            input int nb, input int base, input logic [7:0] lkeep);
    for (int i = 0; i < nb; i++)
      dq.push_back({(i == nb - 1), ((i == nb - 1) ? lkeep : 8'hFF), pat(base, i)});
    cq.push_back({cntrl, ins, sum});
  endtask

  // One clock: present FWFT FIFO heads, sample just after the previous edge, pop on the edge.
  task automatic tick();
    ctrl_fifo_empty = (cq.size() == 0);
    ctrl_fifo_rdata = ctrl_fifo_empty ? 34'd0 : cq[0];
    data_fifo_empty = (dq.size() == 0) || dstall;
    data_fifo_rdata = (dq.size() == 0) ? 73'd0 : dq[0];
    tx_axis_tready  = rdy;
    #1;
    s_crd = ctrl_fifo_rden;
    s_drd = data_fifo_rden;
    s_tv  = tx_axis_tvalid;
    s_tl  = tx_axis_tlast;
    s_tk  = tx_axis_tkeep;
    s_td  = tx_axis_tdata;
    if (s_crd && s_drd) both_seen = 1'b1;
    if (cs_unsupported) unsup_cnt++;
    if (tx_axis_tvalid && tx_axis_tready) begin
      cap.push_back({tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata});
      cap_cyc.push_back(cyc);
    end
    @(posedge tx_clk);
    #1;
    if (s_crd) cq.delete(0);
    if (s_drd) dq.delete(0);
    cyc++;
  endtask

  task automatic run_until(input string tag, input int n);
    int budget = 200;
    while (cap.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    if (cap.size() < n) chk({tag, ".timeout"}, cap.size(), n);
  endtask

  task automatic run_vec(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rdy = vt[i].rdy;
      tick();
      chk($sformatf("%s[%0d].ctrl_rden", tag, i - lo), s_crd, vt[i].crd);
      chk($sformatf("%s[%0d].data_rden", tag, i - lo), s_drd, vt[i].drd);
      chk($sformatf("%s[%0d].tvalid", tag, i - lo), s_tv, vt[i].tv);
      if (vt[i].tv) begin
        chk($sformatf("%s[%0d].tdata", tag, i - lo), s_td, vt[i].td);
        chk($sformatf("%s[%0d].tkeep", tag, i - lo), s_tk, vt[i].tk);
        chk($sformatf("%s[%0d].tlast", tag, i - lo), s_tl, vt[i].tl);
      end
    end
    rdy = 1'b1;
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [63:0] d,
                          input logic [7:0] k, input logic l);
    if (cap.size() > i) begin
      chk($sformatf("%s.b%0d.tdata", tag, i), cap[i][63:0], d);
      chk($sformatf("%s.b%0d.tkeep", tag, i), cap[i][71:64], k);
      chk($sformatf("%s.b%0d.tlast", tag, i), cap[i][72], l);
    end
  endtask

  initial begin
    logic [63:0] e;
    logic [15:0] zero_word;

    // T1: passthrough, 3 beats, keep FF FF 0F
    vt[0]  = mkv(1, 1, 0, 0, 0, 8'h00, 64'h0);
    vt[1]  = mkv(1, 0, 1, 0, 0, 8'h00, 64'h0);
    vt[2]  = mkv(1, 0, 1, 1, 0, 8'hFF, pat(8'h10, 0));
    vt[3]  = mkv(1, 0, 1, 1, 0, 8'hFF, pat(8'h10, 1));
    vt[4]  = mkv(1, 0, 0, 1, 1, 8'h0F, pat(8'h10, 2));
    vt[5]  = mkv(1, 0, 0, 0, 0, 8'h00, 64'h0);
    // T3: tready low 4 cycles while beat 1 is presented
    vt[6]  = mkv(1, 1, 0, 0, 0, 8'h00, 64'h0);
    vt[7]  = mkv(1, 0, 1, 0, 0, 8'h00, 64'h0);
    vt[8]  = mkv(1, 0, 1, 1, 0, 8'hFF, pat(8'h30, 0));
    vt[9]  = mkv(0, 0, 0, 1, 0, 8'hFF, pat(8'h30, 1));
    vt[10] = mkv(0, 0, 0, 1, 0, 8'hFF, pat(8'h30, 1));
    vt[11] = mkv(0, 0, 0, 1, 0, 8'hFF, pat(8'h30, 1));
    vt[12] = mkv(0, 0, 0, 1, 0, 8'hFF, pat(8'h30, 1));
    vt[13] = mkv(1, 0, 1, 1, 0, 8'hFF, pat(8'h30, 1));
    vt[14] = mkv(1, 0, 0, 1, 1, 8'hFF, pat(8'h30, 2));
    vt[15] = mkv(1, 0, 0, 0, 0, 8'h00, 64'h0);

`ifdef OFM_UDP_ZERO_FIX_EN
    zero_word = 16'hFFFF;
`else
    zero_word = 16'h0000;
`endif
    // Insertion cases: word is the tdata slice at the lane (byte L+1 in the upper half)
    it[0] = mki(2'b01, 16'h0028, 16'hBEEF, 8,  5, 0, 16'hEFBE);
    it[1] = mki(2'b01, 16'h0016, 16'h1234, 4,  2, 6, 16'h3412);
    it[2] = mki(2'b01, 16'h0040, 16'hAAAA, 4, -1, 0, 16'h0000);
    it[3] = mki(2'b00, 16'h0008, 16'hBEEF, 3, -1, 0, 16'h0000);
    it[4] = mki(2'b11, 16'h0008, 16'hBEEF, 3, -1, 0, 16'h0000);
    it[5] = mki(2'b01, 16'h0010, 16'h0000, 3,  2, 0, zero_word);

    tx_reset        = 1'b1;
    ctrl_fifo_empty = 1'b1;
    data_fifo_empty = 1'b1;
    ctrl_fifo_rdata = '0;
    data_fifo_rdata = '0;
    tx_axis_tready  = 1'b1;
    repeat (3) @(posedge tx_clk);
    #1;
    chk("reset.tvalid", tx_axis_tvalid, 0);
    chk("reset.tdata", tx_axis_tdata, 0);
    chk("reset.tkeep", tx_axis_tkeep, 0);
    chk("reset.tlast", tx_axis_tlast, 0);
    chk("reset.dbg", ofm_out_fsm_dbg, 0);
    chk("reset.rden", {ctrl_fifo_rden, data_fifo_rden, cs_unsupported}, 0);
    tx_reset = 1'b0;
    @(posedge tx_clk);
    #1;

    // T1
    push_frame(2'b00, 16'h0000, 16'h0000, 3, 8'h10, 8'h0F);
    run_vec("t1", 0, 5);

    // T3
    cap.delete(); cap_cyc.delete();
    push_frame(2'b00, 16'h0000, 16'h0000, 3, 8'h30, 8'hFF);
    run_vec("t3", 6, 15);
    chk("t3.beats", cap.size(), 3);
    for (int i = 0; i < 3; i++) chk_beat("t3", i, pat(8'h30, i), 8'hFF, i == 2);

    // T2/T6: insertion table
    for (int n = 0; n < 6; n++) begin
      cap.delete(); cap_cyc.delete();
      push_frame(it[n].cntrl, it[n].ins, it[n].sum, it[n].nb, 8'h40 + n, 8'hFF);
      run_until($sformatf("ins%0d", n), it[n].nb);
      for (int i = 0; i < it[n].nb; i++) begin
        e = pat(8'h40 + n, i);
        if (i == it[n].hit_beat) e[it[n].lane*8 +: 16] = it[n].word;
        chk_beat($sformatf("ins%0d", n), i, e, 8'hFF, i == it[n].nb - 1);
      end
      repeat (2) tick();
    end

    // T4: 3-cycle underrun mid-frame
    cap.delete(); cap_cyc.delete();
    push_frame(2'b00, 16'h0000, 16'h0000, 6, 8'h50, 8'hFF);
    for (int k = 0; k < 60 && cap.size() < 6; k++) begin
      dstall = (k >= 4 && k <= 6);
      tick();
    end
    dstall = 1'b0;
    chk("t4.beats", cap.size(), 6);
    for (int i = 0; i < 6; i++) chk_beat("t4", i, pat(8'h50, i), 8'hFF, i == 5);
    if (cap_cyc.size() == 6) begin
      chk("t4.gap01", cap_cyc[1] - cap_cyc[0] - 1, 0);
      chk("t4.gap23", cap_cyc[3] - cap_cyc[2] - 1, 3);
      chk("t4.gap34", cap_cyc[4] - cap_cyc[3] - 1, 0);
    end
    repeat (2) tick();

    // T4: two queued frames back-to-back
    cap.delete(); cap_cyc.delete();
    push_frame(2'b00, 16'h0000, 16'h0000, 2, 8'h60, 8'hFF);
    push_frame(2'b00, 16'h0000, 16'h0000, 2, 8'h70, 8'h3F);
    run_until("t4b", 4);
    chk_beat("t4b", 0, pat(8'h60, 0), 8'hFF, 0);
    chk_beat("t4b", 1, pat(8'h60, 1), 8'hFF, 1);
    chk_beat("t4b", 2, pat(8'h70, 0), 8'hFF, 0);
    chk_beat("t4b", 3, pat(8'h70, 1), 8'h3F, 1);
    if (cap_cyc.size() == 4) chk("t4b.frame_gap", cap_cyc[2] - cap_cyc[1] - 1, 1);
    repeat (2) tick();

    // T5: asynchronous reset mid-frame
    cap.delete(); cap_cyc.delete();
    push_frame(2'b00, 16'h0000, 16'h0000, 4, 8'h80, 8'hFF);
    for (int k = 0; k < 20 && !s_tv; k++) tick();
    chk("t5.midframe_valid", tx_axis_tvalid, 1);
    #2;
    tx_reset = 1'b1;
    #1;
    chk("t5.reset_tvalid", tx_axis_tvalid, 0);
    chk("t5.reset_dbg", ofm_out_fsm_dbg, 0);
    @(posedge tx_clk);
    #1;
    tx_reset = 1'b0;
    cq.delete();
    dq.delete();

    // T5: unsupported control encoding
    cap.delete(); cap_cyc.delete();
    unsup_cnt = 0;
    push_frame(2'b10, 16'h0000, 16'hBEEF, 2, 8'h90, 8'hFF);
    run_until("t5u", 2);
    repeat (3) tick();
    chk("t5u.pulses", unsup_cnt, 1);
    chk_beat("t5u", 0, pat(8'h90, 0), 8'hFF, 0);
    chk_beat("t5u", 1, pat(8'h90, 1), 8'hFF, 1);

    chk("rden_exclusive", both_seen, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
